// File: rtl/packer_ring_pkg.sv
// Shared definitions for the packer ring: FSM state encoding, maximum value
// width and the run-time bitwidth clamp.
package packer_ring_pkg;

    localparam int MAX_BW = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PACK,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Out-of-range widths (0 or above MAX_BW) fall back to the full word width.
    function automatic logic [4:0] clamp_bw(input logic [4:0] bw);
        return (bw == 5'd0 || bw > 5'(MAX_BW)) ? 5'(MAX_BW) : bw;
    endfunction

endpackage

// File: rtl/packer_ring_bit_insert_unit.sv
// Combinational insert: masks a value to bw bits and ORs it into the staging
// accumulator at bit offset 'offset'.
module packer_ring_bit_insert_unit #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0]  acc_in,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [4:0]            bw,
    input  logic [5:0]            offset,
    output logic [ACC_WIDTH-1:0]  acc_out
);

    logic [DATA_WIDTH-1:0] mask;
    logic [ACC_WIDTH-1:0]  value_ext;

    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i] = (5'(i) < bw);
        end
    end

    // Bits above the inserted value stay zero, so the accumulator never
    // carries sign-extension garbage into later words.
    assign value_ext = ACC_WIDTH'(value & mask);
    assign acc_out   = acc_in | (value_ext << offset);

endmodule

// File: rtl/packer_ring.sv
// Packs a stream of bw-bit values LSB-first into dense 16-bit words, flushing
// a zero-padded partial word at the end of each job.
module packer_ring
    import packer_ring_pkg::*;
#(
    parameter int MAX_BITWIDTH_QUANTIZED_DATA = MAX_BW,
    parameter int ACC_WIDTH                   = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [4:0]                             bitwidth_d,
    input  logic [31:0]                            num_of_input_vals,
    input  logic                                   rcv_valid,
    input  logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0] rcv_data,
    output logic                                   rcv_ready,
    output logic                                   trm_valid,
    output logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0] trm_data,
    input  logic                                   trm_ready,
    output logic                                   finished
);

    localparam logic [5:0] WORD_BITS = 6'(MAX_BITWIDTH_QUANTIZED_DATA);

    state_t               state, state_next;
    logic [ACC_WIDTH-1:0] acc;
    logic [5:0]           fill;
    logic [4:0]           bw_q;
    logic [31:0]          n_q;
    logic [31:0]          vals_in;
    logic [32:0]          words_out;
    logic [32:0]          total_words;

    logic                 start_take;
    logic                 rcv_fire;
    logic                 trm_fire;
    logic [4:0]           bw_start;
    logic [36:0]          total_calc;
    logic [ACC_WIDTH-1:0] acc_shifted;
    logic [ACC_WIDTH-1:0] acc_inserted;
    logic [5:0]           fill_base;

    assign bw_start   = clamp_bw(bitwidth_d);
    assign total_calc = {5'd0, num_of_input_vals} * {32'd0, bw_start} + 37'd15;
    assign start_take = start & ((state == ST_IDLE) | (state == ST_DONE));
    assign rcv_fire   = rcv_valid & rcv_ready;
    assign trm_fire   = trm_valid & trm_ready;
    assign trm_data   = acc[MAX_BITWIDTH_QUANTIZED_DATA-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_next = state;
        rcv_ready  = 1'b0;
        trm_valid  = 1'b0;
        finished   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_take)
                    state_next = (num_of_input_vals == 32'd0) ? ST_DONE : ST_PACK;
            end
            ST_PACK: begin
                rcv_ready = (fill < WORD_BITS) && (vals_in < n_q);
                trm_valid = (fill >= WORD_BITS);
                if (words_out == total_words)
                    state_next = ST_DONE;
                else if ((vals_in == n_q) && (fill != 6'd0) && (fill < WORD_BITS))
                    state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                trm_valid = 1'b1;
                if (trm_ready) state_next = ST_DONE;
            end
            ST_DONE: begin
                finished = 1'b1;
                if (start_take)
                    state_next = (num_of_input_vals == 32'd0) ? ST_DONE : ST_PACK;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A word leaving shifts first; a value arriving is then placed at the post-shift fill.
    assign acc_shifted = trm_fire ? (acc >> MAX_BITWIDTH_QUANTIZED_DATA) : acc;
    assign fill_base   = !trm_fire             ? fill :
                         (state == ST_FLUSH)   ? 6'd0 : fill - WORD_BITS;

    packer_ring_bit_insert_unit #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (MAX_BITWIDTH_QUANTIZED_DATA)
    ) u_insert (
        .acc_in  (acc_shifted),
        .value   (rcv_data),
        .bw      (bw_q),
        .offset  (fill_base),
        .acc_out (acc_inserted)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            acc         <= '0;
            fill        <= '0;
            bw_q        <= '0;
            n_q         <= '0;
            vals_in     <= '0;
            words_out   <= '0;
            total_words <= '0;
        end else if (start_take) begin
            bw_q        <= bw_start;
            n_q         <= num_of_input_vals;
            total_words <= 33'(total_calc >> 4);
            acc         <= '0;
            fill        <= '0;
            vals_in     <= '0;
            words_out   <= '0;
        end else begin
            if (rcv_fire || trm_fire) begin
                acc  <= rcv_fire ? acc_inserted : acc_shifted;
                fill <= fill_base + (rcv_fire ? {1'b0, bw_q} : 6'd0);
            end
            if (rcv_fire) vals_in   <= vals_in + 32'd1;
            if (trm_fire) words_out <= words_out + 33'd1;
        end
    end

endmodule

// File: tb/tb_packer_ring.sv
// Directed bench for packer_ring: hand-computed word streams, a bit-level
// unpack round trip under random handshakes, and mid-job reset recovery.
module tb_packer_ring;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  bitwidth_d;
    logic [31:0] num_of_input_vals;
    logic        rcv_valid;
    logic [15:0] rcv_data;
    logic        rcv_ready;
    logic        trm_valid;
    logic [15:0] trm_data;
    logic        trm_ready;
    logic        finished;

    always #5 clk = ~clk;

    packer_ring dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .bitwidth_d        (bitwidth_d),
        .num_of_input_vals (num_of_input_vals),
        .rcv_valid         (rcv_valid),
        .rcv_data          (rcv_data),
        .rcv_ready         (rcv_ready),
        .trm_valid         (trm_valid),
        .trm_data          (trm_data),
        .trm_ready         (trm_ready),
        .finished          (finished)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          hold_err;
    logic [15:0] vin[$];
    logic [15:0] wout[$];
    logic [159:0] stream;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Runs one job: start pulse, then feed vin and collect words until finished
    // (or until stop_words words have been collected when stop_words >= 0).
    task automatic run_job(input string tag, input logic [4:0] bw, input int n,
                           input bit rand_hs, input int stop_words);
        int          idx   = 0;
        bit          pend  = 1'b0;
        logic [15:0] pdata = 16'h0;
        bit          done  = 1'b0;
        wout.delete();
        hold_err = 0;
        @(negedge clk);
        bitwidth_d        = bw;
        num_of_input_vals = n;
        start             = 1'b1;
        @(negedge clk);
        start             = 1'b0;
        bitwidth_d        = 5'd3;      // must be ignored until the next start
        num_of_input_vals = 32'd7;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (finished || (stop_words >= 0 && wout.size() == stop_words)) begin
                done = 1'b1;
                break;
            end
            rcv_valid = (idx < vin.size()) && (!rand_hs || $urandom_range(0, 3) != 0);
            rcv_data  = (idx < vin.size()) ? vin[idx] : 16'h0;
            trm_ready = rand_hs ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (pend && (!trm_valid || trm_data !== pdata)) hold_err++;
            if (rcv_valid && rcv_ready) idx++;
            if (trm_valid && trm_ready) wout.push_back(trm_data);
            pend  = trm_valid && !trm_ready;
            pdata = trm_data;
            @(negedge clk);
        end
        rcv_valid = 1'b0;
        rcv_data  = 16'h0;
        trm_ready = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        if (stop_words < 0) check({tag, " consumed"}, idx, n);
        check({tag, " hold"}, hold_err, 0);
    endtask

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        bitwidth_d        = 5'd0;
        num_of_input_vals = 32'd0;
        rcv_valid         = 1'b0;
        rcv_data          = 16'h0;
        trm_ready         = 1'b0;
        #12;
        check("reset rcv_ready", 32'(rcv_ready), 32'd0);
        check("reset trm_valid", 32'(trm_valid), 32'd0);
        check("reset trm_data",  32'(trm_data),  32'd0);
        check("reset finished",  32'(finished),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        vin = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_job("t1", 5'd5, 4, 1'b0, -1);
        check("t1 count", wout.size(), 2);
        check("t1 w0", 32'(wout[0]), 32'h0C41);
        check("t1 w1", 32'(wout[1]), 32'h0002);

        vin = '{16'hFFFF, 16'hFFF8, 16'h0007, 16'h0000};
        run_job("t2", 5'd4, 4, 1'b0, -1);
        check("t2 count", wout.size(), 1);
        check("t2 w0", 32'(wout[0]), 32'h078F);

        vin = '{16'h8001, 16'h7FFF, 16'h1234};
        run_job("t3", 5'd16, 3, 1'b0, -1);
        check("t3 count", wout.size(), 3);
        check("t3 w0", 32'(wout[0]), 32'h8001);
        check("t3 w1", 32'(wout[1]), 32'h7FFF);
        check("t3 w2", 32'(wout[2]), 32'h1234);

        vin.delete();
        for (int k = 0; k < 11; k++) vin.push_back(16'hFFFF);
        run_job("t4", 5'd3, 11, 1'b0, -1);
        check("t4 count", wout.size(), 3);
        check("t4 w0", 32'(wout[0]), 32'hFFFF);
        check("t4 w1", 32'(wout[1]), 32'hFFFF);
        check("t4 w2", 32'(wout[2]), 32'h0001);

        vin = '{16'h1234};
        run_job("bw0", 5'd0, 1, 1'b0, -1);
        check("bw0 count", wout.size(), 1);
        check("bw0 w0", 32'(wout[0]), 32'h1234);

        vin.delete();
        run_job("n0", 5'd4, 0, 1'b0, -1);
        check("n0 count", wout.size(), 0);

        vin.delete();
        for (int k = 0; k < 20; k++) vin.push_back(16'($urandom));
        run_job("t5", 5'd7, 20, 1'b1, -1);
        check("t5 count", wout.size(), 9);
        stream = '0;
        for (int j = 0; j < wout.size() && j < 10; j++) stream[16*j +: 16] = wout[j];
        for (int k = 0; k < 20; k++)
            check($sformatf("t5 val%0d", k), 32'(stream[k*7 +: 7]), 32'(vin[k][6:0]));
        check("t5 pad", 32'(stream[159:140]), 32'd0);

        vin.delete();
        for (int k = 0; k < 20; k++) vin.push_back(16'(k + 1));
        run_job("t6a", 5'd5, 20, 1'b0, 2);
        rst = 1'b1;
        #1;
        check("t6 rst rcv_ready", 32'(rcv_ready), 32'd0);
        check("t6 rst trm_valid", 32'(trm_valid), 32'd0);
        check("t6 rst trm_data",  32'(trm_data),  32'd0);
        check("t6 rst finished",  32'(finished),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        vin = '{16'h00AB, 16'h00CD};
        run_job("t6b", 5'd8, 2, 1'b0, -1);
        check("t6b count", wout.size(), 1);
        check("t6b w0", 32'(wout[0]), 32'hCDAB);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
